// File: rtl/arcade_input_ctrl.sv
// Purpose:      input conditioning for the galaxian core (PS/2 keys + two joysticks -> P1/P2 CSJUDLR).
// Latency:      joystick/rotate change -> outputs 1 clk_sys edge; PS/2 key event -> 2 edges.
// Backpressure: none; this is a free-running level path, and all outputs are registered every cycle.
//
// Ports:
//   clk_sys     system clock (single domain)
//   RESET_N     synchronous reset, active-low
//   ps2_key     hps_io key packet: [64] toggles per event, [15:8]=F0 on release, E0 marks extended keys
//   joystick_0  hps_io joystick: [0]R [1]L [2]D [3]U [4]fire [5]start1 [6]start2
//   joystick_1  same layout as joystick_0; OR-merged with it
//   rotate      1 = horizontal cabinet; directions are remapped by 90 degrees
//   p1_csjudlr  {coin,start1,fire,up,down,left,right}
//   p2_csjudlr  {1'b0,start2,fire,up,down,left,right}
//   coin_busy   high while a coin pulse or its lockout gap is in progress
module arcade_input_ctrl #(
  parameter int COIN_PULSE = 1200000,  // coin-high duration in clk_sys cycles, >= 1
  parameter int COIN_GAP   = 1200000   // coin-low lockout after each pulse, >= 1
) (
  input  logic        clk_sys,
  input  logic        RESET_N,
  input  logic [64:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  output logic [6:0]  p1_csjudlr,
  output logic [6:0]  p2_csjudlr,
  output logic        coin_busy
);

  // Counter only needs to hold the larger of the two reload values (N-1).
  localparam int CNT_MAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    COIN_IDLE  = 2'd0,
    COIN_PULSE_ST = 2'd1,
    COIN_GAP_ST   = 2'd2
  } coin_state_t;

  // ---------------------------------------------------------------------------
  // PS/2 key decode
  // ---------------------------------------------------------------------------
  logic key_hist;
  logic key_evt;
  logic key_pressed;
  logic key_ext;
  logic key_valid;

  logic key_up, key_down, key_left, key_right;
  logic key_fire, key_start1, key_start2;

  assign key_evt     = ps2_key[64] ^ key_hist;
  assign key_pressed = (ps2_key[15:8] != 8'hF0);
  // On a release the E0 prefix sits one byte further up, behind the F0.
  assign key_ext     = key_pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
  // Packets with anything in the upper bytes are multi-byte sequences we do not decode.
  assign key_valid   = key_evt && (ps2_key[63:24] == 40'd0);

  always_ff @(posedge clk_sys) begin
    if (!RESET_N) begin
      // Adopt the current toggle level so leaving reset never looks like an event.
      key_hist   <= ps2_key[64];
      key_up     <= 1'b0;
      key_down   <= 1'b0;
      key_left   <= 1'b0;
      key_right  <= 1'b0;
      key_fire   <= 1'b0;
      key_start1 <= 1'b0;
      key_start2 <= 1'b0;
    end else begin
      key_hist <= ps2_key[64];
      if (key_valid) begin
        case (ps2_key[7:0])
          // Arrow keys: accept with or without the E0 prefix (keypad arrows too).
          8'h75: key_up    <= key_pressed;
          8'h72: key_down  <= key_pressed;
          8'h6B: key_left  <= key_pressed;
          8'h74: key_right <= key_pressed;
          // Space / left ctrl. E0 14 is right ctrl and E0 29 does not exist; leave them unmapped.
          8'h29, 8'h14: if (!key_ext) key_fire   <= key_pressed;
          8'h05:        if (!key_ext) key_start1 <= key_pressed;
          8'h06:        if (!key_ext) key_start2 <= key_pressed;
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Merge keyboard + both joysticks, then rotate
  // ---------------------------------------------------------------------------
  logic [6:0] joy;
  logic       src_up, src_down, src_left, src_right;
  logic       m_up, m_down, m_left, m_right;
  logic       m_fire, m_start1, m_start2;
  logic       start_any;
  logic       unused_joy;

  assign joy        = joystick_0[6:0] | joystick_1[6:0];
  assign unused_joy = ^{joystick_0[15:7], joystick_1[15:7]};

  assign src_right = key_right | joy[0];
  assign src_left  = key_left  | joy[1];
  assign src_down  = key_down  | joy[2];
  assign src_up    = key_up    | joy[3];
  assign m_fire    = key_fire   | joy[4];
  assign m_start1  = key_start1 | joy[5];
  assign m_start2  = key_start2 | joy[6];
  assign start_any = m_start1 | m_start2;

  // Horizontal orientation: the stick is turned 90 degrees relative to the screen.
  assign m_up    = rotate ? src_left  : src_up;
  assign m_down  = rotate ? src_right : src_down;
  assign m_left  = rotate ? src_down  : src_left;
  assign m_right = rotate ? src_up    : src_right;

  // ---------------------------------------------------------------------------
  // Coin FSM
  // ---------------------------------------------------------------------------
  coin_state_t   coin_state, coin_state_nxt;
  logic [CW-1:0] coin_cnt,   coin_cnt_nxt;
  logic          start_prev;
  logic          coin_trig;

  assign coin_trig = start_any & ~start_prev;

  always_ff @(posedge clk_sys) begin
    if (!RESET_N) begin
      coin_state <= COIN_IDLE;
      coin_cnt   <= '0;
      // Load the live start level so a start held across reset is not seen as a new press.
      start_prev <= start_any;
    end else begin
      coin_state <= coin_state_nxt;
      coin_cnt   <= coin_cnt_nxt;
      start_prev <= start_any;
    end
  end

  always_comb begin
    coin_state_nxt = coin_state;
    coin_cnt_nxt   = coin_cnt;
    case (coin_state)
      COIN_IDLE: begin
        if (coin_trig) begin
          coin_state_nxt = COIN_PULSE_ST;
          coin_cnt_nxt   = CW'(COIN_PULSE - 1);
        end
      end
      COIN_PULSE_ST: begin
        if (coin_cnt == '0) begin
          coin_state_nxt = COIN_GAP_ST;
          coin_cnt_nxt   = CW'(COIN_GAP - 1);
        end else begin
          coin_cnt_nxt = coin_cnt - CW'(1);
        end
      end
      COIN_GAP_ST: begin
        if (coin_cnt == '0) begin
          coin_state_nxt = COIN_IDLE;
        end else begin
          coin_cnt_nxt = coin_cnt - CW'(1);
        end
      end
      default: begin
        coin_state_nxt = COIN_IDLE;
        coin_cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output registers. Coin/busy come from the next state so the coin bit rises
  // on the same edge as the start bit that triggered it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (!RESET_N) begin
      p1_csjudlr <= 7'd0;
      p2_csjudlr <= 7'd0;
      coin_busy  <= 1'b0;
    end else begin
      p1_csjudlr <= {(coin_state_nxt == COIN_PULSE_ST), m_start1, m_fire,
                     m_up, m_down, m_left, m_right};
      p2_csjudlr <= {1'b0, m_start2, m_fire, m_up, m_down, m_left, m_right};
      coin_busy  <= (coin_state_nxt != COIN_IDLE);
    end
  end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
module tb_arcade_input_ctrl;

  logic        clk_sys = 1'b0;
  logic        RESET_N;
  logic [64:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        rotate;
  logic [6:0]  p1_csjudlr;
  logic [6:0]  p2_csjudlr;
  logic        coin_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  arcade_input_ctrl #(.COIN_PULSE(4), .COIN_GAP(3)) dut (
    .clk_sys    (clk_sys),
    .RESET_N    (RESET_N),
    .ps2_key    (ps2_key),
    .joystick_0 (joystick_0),
    .joystick_1 (joystick_1),
    .rotate     (rotate),
    .p1_csjudlr (p1_csjudlr),
    .p2_csjudlr (p2_csjudlr),
    .coin_busy  (coin_busy)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic send_key(input logic [23:0] code, input logic [39:0] hi);
    ps2_key = {~ps2_key[64], hi, code};
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; ps2_key = '0; joystick_0 = '0; joystick_1 = '0; rotate = 1'b0;
    @(negedge clk_sys);
    tick(); tick();
    checks++; if (p1_csjudlr !== 7'd0) begin errors++; $display("FAIL reset_p1: got %b want %b", p1_csjudlr, 7'd0); end
    checks++; if (p2_csjudlr !== 7'd0) begin errors++; $display("FAIL reset_p2: got %b want %b", p2_csjudlr, 7'd0); end
    checks++; if (coin_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", coin_busy); end
    RESET_N = 1'b1;
    tick(); tick();
    checks++; if (p1_csjudlr !== 7'd0) begin errors++; $display("FAIL post_reset_p1: got %b want %b", p1_csjudlr, 7'd0); end
  endtask

  task automatic test_keys();
    send_key(24'h000075, 40'd0);
    tick();
    checks++; if (p1_csjudlr !== 7'd0) begin errors++; $display("FAIL key_up_lat1: got %b want %b", p1_csjudlr, 7'd0); end
    tick();
    checks++; if (p1_csjudlr !== 7'b0001000) begin errors++; $display("FAIL key_up_p1: got %b want %b", p1_csjudlr, 7'b0001000); end
    checks++; if (p2_csjudlr !== 7'b0001000) begin errors++; $display("FAIL key_up_p2: got %b want %b", p2_csjudlr, 7'b0001000); end
    send_key(24'h00F075, 40'd0);
    tick();
    checks++; if (p1_csjudlr !== 7'b0001000) begin errors++; $display("FAIL key_up_rel_lat1: got %b want %b", p1_csjudlr, 7'b0001000); end
    tick();
    checks++; if (p1_csjudlr !== 7'd0) begin errors++; $display("FAIL key_up_rel: got %b want %b", p1_csjudlr, 7'd0); end
    // Upper bytes non-zero: packet must be ignored.
    send_key(24'h000075, 40'h1);
    tick(); tick();
    checks++; if (p1_csjudlr !== 7'd0) begin errors++; $display("FAIL key_ignored: got %b want %b", p1_csjudlr, 7'd0); end
    // Extended arrow make/break.
    send_key(24'h00E075, 40'd0);
    tick(); tick();
    checks++; if (p1_csjudlr !== 7'b0001000) begin errors++; $display("FAIL key_ext_up: got %b want %b", p1_csjudlr, 7'b0001000); end
    send_key(24'hE0F075, 40'd0);
    tick(); tick();
    checks++; if (p1_csjudlr !== 7'd0) begin errors++; $display("FAIL key_ext_up_rel: got %b want %b", p1_csjudlr, 7'd0); end
    // E0 29 is not fire; plain 29 is.
    send_key(24'h00E029, 40'd0);
    tick(); tick();
    checks++; if (p1_csjudlr !== 7'd0) begin errors++; $display("FAIL key_ext_fire: got %b want %b", p1_csjudlr, 7'd0); end
    send_key(24'h000029, 40'd0);
    tick(); tick();
    checks++; if (p1_csjudlr !== 7'b0010000) begin errors++; $display("FAIL key_fire: got %b want %b", p1_csjudlr, 7'b0010000); end
    send_key(24'h00F029, 40'd0);
    tick(); tick();
    checks++; if (p1_csjudlr !== 7'd0) begin errors++; $display("FAIL key_fire_rel: got %b want %b", p1_csjudlr, 7'd0); end
  endtask

  task automatic test_joy_coin();
    int  coin_n = 0, busy_n = 0, rises = 0;
    logic prev = 1'b0;
    joystick_1 = 16'h0020;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) begin
        checks++; if (p1_csjudlr !== 7'b1100000) begin errors++; $display("FAIL joy_start_p1: got %b want %b", p1_csjudlr, 7'b1100000); end
        checks++; if (p2_csjudlr !== 7'd0) begin errors++; $display("FAIL joy_start_p2: got %b want %b", p2_csjudlr, 7'd0); end
      end
      coin_n += int'(p1_csjudlr[6]);
      busy_n += int'(coin_busy);
      if (p1_csjudlr[6] && !prev) rises++;
      prev = p1_csjudlr[6];
    end
    checks++; if (coin_n !== 4) begin errors++; $display("FAIL joy_coin_len: got %0d want 4", coin_n); end
    checks++; if (busy_n !== 7) begin errors++; $display("FAIL joy_busy_len: got %0d want 7", busy_n); end
    checks++; if (rises !== 1) begin errors++; $display("FAIL joy_coin_count: got %0d want 1", rises); end
    checks++; if (p1_csjudlr[5] !== 1'b1) begin errors++; $display("FAIL joy_start_held: got %b want 1", p1_csjudlr[5]); end
    joystick_1 = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    int  coin_n = 0, busy_n = 0, rises = 0, second_rise = -1;
    logic prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      joystick_0 = (i == 0 || i == 2 || i == 5 || i == 9) ? 16'h0020 : 16'h0000;
      tick();
      if (i == 5) begin
        checks++; if (p1_csjudlr !== 7'b0100000) begin errors++; $display("FAIL b2b_gap_press: got %b want %b", p1_csjudlr, 7'b0100000); end
      end
      coin_n += int'(p1_csjudlr[6]);
      busy_n += int'(coin_busy);
      if (p1_csjudlr[6] && !prev) begin
        rises++;
        if (rises == 2) second_rise = i;
      end
      prev = p1_csjudlr[6];
    end
    joystick_0 = '0;
    checks++; if (rises !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", rises); end
    checks++; if (second_rise !== 9) begin errors++; $display("FAIL b2b_second_rise: got %0d want 9", second_rise); end
    checks++; if (coin_n !== 8) begin errors++; $display("FAIL b2b_coin_len: got %0d want 8", coin_n); end
    checks++; if (busy_n !== 14) begin errors++; $display("FAIL b2b_busy_len: got %0d want 14", busy_n); end
    tick();
  endtask

  task automatic test_rotate();
    rotate = 1'b1; joystick_0 = 16'h0002;
    tick();
    checks++; if (p1_csjudlr !== 7'b0001000) begin errors++; $display("FAIL rot_left_to_up: got %b want %b", p1_csjudlr, 7'b0001000); end
    joystick_0 = 16'h0008;
    tick();
    checks++; if (p1_csjudlr !== 7'b0000001) begin errors++; $display("FAIL rot_up_to_right: got %b want %b", p1_csjudlr, 7'b0000001); end
    rotate = 1'b0;
    tick();
    checks++; if (p1_csjudlr !== 7'b0001000) begin errors++; $display("FAIL rot_off_up: got %b want %b", p1_csjudlr, 7'b0001000); end
    rotate = 1'b1; joystick_0 = '0;
    send_key(24'h000074, 40'd0);
    tick(); tick();
    checks++; if (p1_csjudlr !== 7'b0000100) begin errors++; $display("FAIL rot_key_right_to_down: got %b want %b", p1_csjudlr, 7'b0000100); end
    send_key(24'h00F074, 40'd0);
    tick(); tick();
    checks++; if (p1_csjudlr !== 7'd0) begin errors++; $display("FAIL rot_key_rel: got %b want %b", p1_csjudlr, 7'd0); end
    rotate = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_pulse();
    int coin_n = 0, busy_n = 0;
    joystick_0 = 16'h0020;
    tick();
    checks++; if (p1_csjudlr[6] !== 1'b1) begin errors++; $display("FAIL rmp_pulse_start: got %b want 1", p1_csjudlr[6]); end
    tick();
    RESET_N = 1'b0;
    tick();
    checks++; if (p1_csjudlr !== 7'd0) begin errors++; $display("FAIL rmp_reset_p1: got %b want %b", p1_csjudlr, 7'd0); end
    checks++; if (coin_busy !== 1'b0) begin errors++; $display("FAIL rmp_reset_busy: got %b want 0", coin_busy); end
    RESET_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) begin
        checks++; if (p1_csjudlr !== 7'b0100000) begin errors++; $display("FAIL rmp_held_p1: got %b want %b", p1_csjudlr, 7'b0100000); end
      end
      coin_n += int'(p1_csjudlr[6]);
    end
    checks++; if (coin_n !== 0) begin errors++; $display("FAIL rmp_no_retrigger: got %0d want 0", coin_n); end
    joystick_0 = '0;
    tick();
    joystick_0 = 16'h0020;
    coin_n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      coin_n += int'(p1_csjudlr[6]);
      busy_n += int'(coin_busy);
    end
    checks++; if (coin_n !== 4) begin errors++; $display("FAIL rmp_repress_coin: got %0d want 4", coin_n); end
    checks++; if (busy_n !== 7) begin errors++; $display("FAIL rmp_repress_busy: got %0d want 7", busy_n); end
    joystick_0 = '0;
    tick();
  endtask

  task automatic test_both_starts();
    int  coin_n = 0, rises = 0, p2_coin = 0;
    logic prev = 1'b0;
    joystick_0 = 16'h0020; joystick_1 = 16'h0040;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) begin
        checks++; if (p1_csjudlr !== 7'b1100000) begin errors++; $display("FAIL both_p1: got %b want %b", p1_csjudlr, 7'b1100000); end
        checks++; if (p2_csjudlr !== 7'b0100000) begin errors++; $display("FAIL both_p2: got %b want %b", p2_csjudlr, 7'b0100000); end
      end
      coin_n  += int'(p1_csjudlr[6]);
      p2_coin += int'(p2_csjudlr[6]);
      if (p1_csjudlr[6] && !prev) rises++;
      prev = p1_csjudlr[6];
    end
    checks++; if (rises !== 1) begin errors++; $display("FAIL both_pulses: got %0d want 1", rises); end
    checks++; if (coin_n !== 4) begin errors++; $display("FAIL both_coin_len: got %0d want 4", coin_n); end
    checks++; if (p2_coin !== 0) begin errors++; $display("FAIL both_p2_bit6: got %0d want 0", p2_coin); end
    joystick_0 = '0; joystick_1 = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_keys();
    test_joy_coin();
    test_back_to_back();
    test_rotate();
    test_reset_mid_pulse();
    test_both_starts();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
